multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, giving the number of EXEC cycles a MUL occupies (legal range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port opcode  input  6  instruction opcode from the datapath instruction register, valid from DECODE onward.
REQ-005 SHALL have port zero  input  1  ALU result equals zero.
REQ-006 SHALL have port sign  input  1  ALU result bit 31.
REQ-007 SHALL have port hold  input  1  stall request; freezes the FSM while high.
REQ-008 SHALL have port pc_write  output  1  PC register load enable.
REQ-009 SHALL have port pc_src  output  2  next-PC select: 0 PC+1, 1 branch target, 2 jump target, 3 register (JR).
REQ-010 SHALL have port ir_write  output  1  instruction register load enable.
REQ-011 SHALL have the following datapath control ports:
- reg_write  output  1  register file write enable.
- mem_read  output  1  data memory read strobe.
- mem_write  output  1  data memory write strobe.
- mem_size  output  2  access size: 0 byte, 1 half, 2 word.
- alu_op  output  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 NOR, 4 OR, 5 SLT, 6 LUI, 7 MUL.
- alu_src_b  output  1  ALU operand B: 0 register, 1 immediate.
- reg_dst  output  2  write register select: 0 rd, 1 rt, 2 r31.
- mem_to_reg  output  2  writeback source: 0 ALU, 1 memory, 2 PC (link).
REQ-012 SHALL have the following status ports:
- state  output  3  current FSM state.
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
- instr_count  output  16  count of retired instructions.
- illegal  output  1  sticky illegal-opcode flag.

Function
REQ-013 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-014 FETCH SHALL assert ir_write=1 and pc_write=1 with pc_src=0, then advance to DECODE.
REQ-015 DECODE SHALL latch opcode into an internal op_q, which drives all later decoding.
REQ-016 DECODE SHALL go to HALT if opcode>24; otherwise it SHALL go to EXEC.
REQ-017 R-type ADD/SUB/AND/NOR/OR/SLT (opcodes 0-5) SHALL use alu_op equal to the opcode and alu_src_b=0 in EXEC.
REQ-018 WB for opcodes 0-5 SHALL assert reg_write=1 with reg_dst=0; total 4 cycles.
REQ-019 ADDI/SUBI/ANDI/ORI/SLTI/LUI (6-10, 14) SHALL use alu_op ADD/SUB/AND/OR/SLT/LUI and alu_src_b=1 in EXEC, then reg_write with reg_dst=1 in WB; total 4 cycles.
REQ-020 LB/LH/LW (11-13) SHALL follow EXEC(ADD, imm) -> MEM(mem_read=1, mem_size 0/1/2) -> WB(reg_write, reg_dst=1, mem_to_reg=1); total 5 cycles.
REQ-021 SB/SH/SW (16-18) SHALL follow EXEC(ADD, imm) -> MEM(mem_write=1, mem_size 0/1/2); total 4 cycles, no WB.
REQ-022 BEQ/BNEQ/BGEZ (19-21) SHALL use alu_op=SUB in EXEC and set pc_src=1 with pc_write equal to zero, !zero, or !sign respectively; total 3 cycles.
REQ-023 J SHALL assert pc_src=2 with pc_write=1 in EXEC; total 3 cycles.
REQ-024 JAL SHALL do the same as J and also assert reg_write=1 with reg_dst=2 and mem_to_reg=2 in the same cycle.
REQ-025 JR SHALL assert pc_src=3 with pc_write=1 in EXEC.
REQ-026 All outputs not named for a state SHALL be 0 in that state.
REQ-027 instr_done SHALL pulse on the final state of each instruction.
REQ-028 instr_count SHALL increment on each instr_done and wrap from 0xFFFF to 0x0000.
REQ-029 While hold=1, state, op_q, the MUL counter and instr_count SHALL hold their values.
REQ-030 While hold=1, pc_write, ir_write, reg_write, mem_read, mem_write and instr_done SHALL be forced to 0.
REQ-031 When hold falls, the FSM SHALL resume the frozen state that cycle.
REQ-032 HALT SHALL set illegal=1, assert no strobes and be left only by reset; hold has no effect in HALT.

Reset
REQ-033 rst_n low SHALL immediately force state=FETCH, op_q=0, MUL counter=0, instr_count=0 and illegal=0.
REQ-034 Reset mid-instruction SHALL abandon the instruction without retiring it.
REQ-035 The first FETCH SHALL occur on the first rising clk edge after rst_n rises.

Configuration
REQ-036 With MUL_MULTICYCLE_EN defined, MUL (15) SHALL stay in EXEC with alu_op=7 for exactly MUL_CYCLES cycles, counted by a 4-bit counter, then go to WB with reg_write=1 and reg_dst=0; total 3+MUL_CYCLES cycles.
REQ-037 Without MUL_MULTICYCLE_EN, opcode 15 SHALL be illegal and go to HALT from DECODE.

Verification
REQ-038 Reset, then ADD (0) with hold=0 -> states 0,1,2,4; reg_write=1 only in cycle 4; instr_done once; instr_count=1.
REQ-039 LW (13) -> 5 cycles, mem_read=1 with mem_size=2 in MEM, mem_to_reg=1 in WB; SW (18) -> 4 cycles, mem_write=1 in MEM only.
REQ-040 BEQ with zero=1 -> pc_write=1 with pc_src=1 in EXEC; BEQ with zero=0 -> pc_write=0; BGEZ with sign=1 -> not taken.
REQ-041 hold=1 for 3 cycles starting in MEM of LB -> state stays 3 with mem_read=0; after release, mem_read=1 for one cycle, then WB.
REQ-042 Opcode 6'h3F -> HALT (state=7) with illegal=1; after 10 clocks still HALT; rst_n pulse -> FETCH with illegal=0.
REQ-043 MUL with MUL_MULTICYCLE_EN and MUL_CYCLES=4 -> EXEC lasts 4 cycles (7 total); without the macro -> HALT after DECODE.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM; MUL_MULTICYCLE_EN enables the iterative MUL (opcode 15)
module multicycle_control #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        sign,
    input  logic        hold,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [2:0]  alu_op,
    output logic        alu_src_b,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic [15:0] instr_count,
    output logic        illegal
);

`ifdef MUL_MULTICYCLE_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    localparam logic [3:0] MulLast = 4'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [3:0]  mul_cnt_q, mul_cnt_d;
    logic [15:0] count_q, count_d;
    logic        illegal_q, illegal_d;

    logic pc_write_raw, ir_write_raw, reg_write_raw;
    logic mem_read_raw, mem_write_raw, done_raw;

    logic is_rtype, is_itype, is_load, is_store, is_branch;
    logic is_j, is_jal, is_jr, is_mul, dec_illegal, br_taken;

    function automatic logic [2:0] imm_alu(input logic [5:0] op);
        case (op)
            6'd6:    imm_alu = 3'd0;
            6'd7:    imm_alu = 3'd1;
            6'd8:    imm_alu = 3'd2;
            6'd9:    imm_alu = 3'd4;
            6'd10:   imm_alu = 3'd5;
            default: imm_alu = 3'd6;
        endcase
    endfunction

    function automatic logic [1:0] access_size(input logic [5:0] op);
        case (op)
            6'd11, 6'd16: access_size = 2'd0;
            6'd12, 6'd17: access_size = 2'd1;
            default:      access_size = 2'd2;
        endcase
    endfunction

    assign is_rtype  = (op_q <= 6'd5);
    assign is_itype  = ((op_q >= 6'd6) && (op_q <= 6'd10)) || (op_q == 6'd14);
    assign is_load   = (op_q >= 6'd11) && (op_q <= 6'd13);
    assign is_store  = (op_q >= 6'd16) && (op_q <= 6'd18);
    assign is_branch = (op_q >= 6'd19) && (op_q <= 6'd21);
    assign is_j      = (op_q == 6'd22);
    assign is_jal    = (op_q == 6'd23);
    assign is_jr     = (op_q == 6'd24);
    assign is_mul    = MulEn && (op_q == 6'd15);

    // The HALT decision uses the live opcode because op_q is only loaded on leaving DECODE
    assign dec_illegal = (opcode > 6'd24) || ((opcode == 6'd15) && !MulEn);

    always_comb begin
        case (op_q)
            6'd19:   br_taken = zero;
            6'd20:   br_taken = !zero;
            default: br_taken = !sign;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        mul_cnt_d     = mul_cnt_q;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        done_raw      = 1'b0;
        pc_src        = 2'd0;
        mem_size      = 2'd0;
        alu_op        = 3'd0;
        alu_src_b     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;

        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                op_d      = opcode;
                mul_cnt_d = 4'd0;
                state_d   = dec_illegal ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (is_rtype) begin
                    alu_op  = op_q[2:0];
                    state_d = S_WB;
                end else if (is_itype) begin
                    alu_op    = imm_alu(op_q);
                    alu_src_b = 1'b1;
                    state_d   = S_WB;
                end else if (is_load || is_store) begin
                    alu_src_b = 1'b1;
                    state_d   = S_MEM;
                end else if (is_branch) begin
                    alu_op       = 3'd1;
                    pc_src       = 2'd1;
                    pc_write_raw = br_taken;
                    done_raw     = 1'b1;
                    state_d      = S_FETCH;
                end else if (is_j || is_jal) begin
                    pc_src       = 2'd2;
                    pc_write_raw = 1'b1;
                    done_raw     = 1'b1;
                    state_d      = S_FETCH;
                    if (is_jal) begin
                        reg_write_raw = 1'b1;
                        reg_dst       = 2'd2;
                        mem_to_reg    = 2'd2;
                    end
                end else if (is_jr) begin
                    pc_src       = 2'd3;
                    pc_write_raw = 1'b1;
                    done_raw     = 1'b1;
                    state_d      = S_FETCH;
                end else if (is_mul) begin
                    alu_op = 3'd7;
                    if (mul_cnt_q == MulLast) begin
                        state_d = S_WB;
                    end else begin
                        mul_cnt_d = mul_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_size = access_size(op_q);
                if (is_load) begin
                    mem_read_raw = 1'b1;
                    state_d      = S_WB;
                end else begin
                    mem_write_raw = 1'b1;
                    done_raw      = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_WB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
                state_d       = S_FETCH;
                if (is_load) begin
                    reg_dst    = 2'd1;
                    mem_to_reg = 2'd1;
                end else if (is_itype) begin
                    reg_dst = 2'd1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A stall freezes all sequencing state; HALT is absorbing regardless
        if (hold && (state_q != S_HALT)) begin
            state_d   = state_q;
            op_d      = op_q;
            mul_cnt_d = mul_cnt_q;
        end
    end

    assign pc_write   = pc_write_raw  & ~hold;
    assign ir_write   = ir_write_raw  & ~hold;
    assign reg_write  = reg_write_raw & ~hold;
    assign mem_read   = mem_read_raw  & ~hold;
    assign mem_write  = mem_write_raw & ~hold;
    assign instr_done = done_raw      & ~hold;

    assign count_d   = count_q + 16'(instr_done);
    assign illegal_d = illegal_q | (state_d == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            mul_cnt_q <= 4'd0;
            count_q   <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mul_cnt_q <= mul_cnt_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    localparam int MUL_CYC = 4;
`ifdef MUL_MULTICYCLE_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic        sign = 1'b0;
    logic        hold = 1'b0;
    logic        pc_write, ir_write, reg_write, mem_read, mem_write;
    logic        alu_src_b, instr_done, illegal;
    logic [1:0]  pc_src, mem_size, reg_dst, mem_to_reg;
    logic [2:0]  alu_op, state;
    logic [15:0] instr_count;

    always #5 clk = ~clk;

    multicycle_control #(.MUL_CYCLES(MUL_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .sign(sign), .hold(hold),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
        .instr_done(instr_done), .instr_count(instr_count), .illegal(illegal)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw, rw, mr, mw;
        logic [1:0] msz;
        logic [2:0] alu;
        logic       srcb;
        logic [1:0] rd, m2r;
        logic       done;
    } out_t;

    typedef struct packed {
        logic [5:0] op;
        logic       z, s, h;
        out_t       o;
    } rec_t;

    out_t act;
    assign act = {state, pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
                  mem_size, alu_op, alu_src_b, reg_dst, mem_to_reg, instr_done};

    rec_t sb[$];
    rec_t r;
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;

    function automatic rec_t base(input logic [5:0] op, input logic z, input logic s, input logic [2:0] st);
        rec_t b;
        b = '0;
        b.op = op; b.z = z; b.s = s; b.o.st = st;
        return b;
    endfunction

    // Per-cycle expected trace of one instruction, hold low throughout
    task automatic push_instr(input logic [5:0] op, input logic z, input logic s);
        rec_t e;
        e = base(op, z, s, 3'd0); e.o.pcw = 1'b1; e.o.irw = 1'b1; sb.push_back(e);
        sb.push_back(base(op, z, s, 3'd1));
        if (op > 6'd24 || (op == 6'd15 && !MUL_EN)) begin
            sb.push_back(base(op, z, s, 3'd7));
            return;
        end
        e = base(op, z, s, 3'd2);
        if (op <= 6'd5) begin
            e.o.alu = op[2:0]; sb.push_back(e);
            e = base(op, z, s, 3'd4); e.o.rw = 1'b1; e.o.done = 1'b1; sb.push_back(e);
        end else if ((op >= 6'd6 && op <= 6'd10) || op == 6'd14) begin
            case (op)
                6'd6:    e.o.alu = 3'd0;
                6'd7:    e.o.alu = 3'd1;
                6'd8:    e.o.alu = 3'd2;
                6'd9:    e.o.alu = 3'd4;
                6'd10:   e.o.alu = 3'd5;
                default: e.o.alu = 3'd6;
            endcase
            e.o.srcb = 1'b1; sb.push_back(e);
            e = base(op, z, s, 3'd4); e.o.rw = 1'b1; e.o.rd = 2'd1; e.o.done = 1'b1; sb.push_back(e);
        end else if (op >= 6'd11 && op <= 6'd13) begin
            e.o.srcb = 1'b1; sb.push_back(e);
            e = base(op, z, s, 3'd3); e.o.mr = 1'b1; e.o.msz = 2'(op - 6'd11); sb.push_back(e);
            e = base(op, z, s, 3'd4); e.o.rw = 1'b1; e.o.rd = 2'd1; e.o.m2r = 2'd1; e.o.done = 1'b1;
            sb.push_back(e);
        end else if (op >= 6'd16 && op <= 6'd18) begin
            e.o.srcb = 1'b1; sb.push_back(e);
            e = base(op, z, s, 3'd3); e.o.mw = 1'b1; e.o.msz = 2'(op - 6'd16); e.o.done = 1'b1;
            sb.push_back(e);
        end else if (op >= 6'd19 && op <= 6'd21) begin
            e.o.alu = 3'd1; e.o.pcs = 2'd1; e.o.done = 1'b1;
            e.o.pcw = (op == 6'd19) ? z : (op == 6'd20) ? !z : !s;
            sb.push_back(e);
        end else if (op == 6'd22 || op == 6'd23) begin
            e.o.pcs = 2'd2; e.o.pcw = 1'b1; e.o.done = 1'b1;
            if (op == 6'd23) begin e.o.rw = 1'b1; e.o.rd = 2'd2; e.o.m2r = 2'd2; end
            sb.push_back(e);
        end else if (op == 6'd24) begin
            e.o.pcs = 2'd3; e.o.pcw = 1'b1; e.o.done = 1'b1; sb.push_back(e);
        end else begin
            for (int i = 0; i < MUL_CYC; i++) begin
                e = base(op, z, s, 3'd2); e.o.alu = 3'd7; sb.push_back(e);
            end
            e = base(op, z, s, 3'd4); e.o.rw = 1'b1; e.o.done = 1'b1; sb.push_back(e);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 3'd0 || instr_count !== 16'd0 || illegal !== 1'b0 || instr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d count=%0d illegal=%b done=%b required 0/0/0/0",
                     state, instr_count, illegal, instr_done);
        end
        rst_n = 1'b1;
        exp_count = 0;
        push_instr(6'd0, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            opcode = r.op; zero = r.z; sign = r.s; hold = r.h;
            #1;
            checks++;
            if (act !== r.o) begin
                errors++;
                $display("FAIL first_add: op=%0d got %h required %h", r.op, act, r.o);
            end
            if (r.o.done) exp_count++;
            @(negedge clk);
        end
        checks++;
        if (instr_count !== 16'd1) begin
            errors++;
            $display("FAIL first_add_count: got %0d required 1", instr_count);
        end
    endtask

    task automatic test_alu;
        logic [5:0] ops [11] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd14};
        foreach (ops[i]) push_instr(ops[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        while (sb.size() > 0) begin
            r = sb.pop_front();
            opcode = r.op; zero = r.z; sign = r.s; hold = r.h;
            #1;
            checks++;
            if (act !== r.o) begin
                errors++;
                $display("FAIL alu: op=%0d got %h required %h", r.op, act, r.o);
            end
            if (r.o.done) exp_count++;
            @(negedge clk);
        end
        checks++;
        if (instr_count !== exp_count[15:0]) begin
            errors++;
            $display("FAIL alu_count: got %0d required %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_mem;
        logic [5:0] ops [6] = '{6'd13, 6'd18, 6'd11, 6'd12, 6'd16, 6'd17};
        foreach (ops[i]) push_instr(ops[i], 1'b0, 1'b0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            opcode = r.op; zero = r.z; sign = r.s; hold = r.h;
            #1;
            checks++;
            if (act !== r.o) begin
                errors++;
                $display("FAIL mem: op=%0d got %h required %h", r.op, act, r.o);
            end
            if (r.o.done) exp_count++;
            @(negedge clk);
        end
    endtask

    task automatic test_branch_jump;
        push_instr(6'd19, 1'b1, 1'b0);
        push_instr(6'd19, 1'b0, 1'b0);
        push_instr(6'd20, 1'b0, 1'b1);
        push_instr(6'd20, 1'b1, 1'b0);
        push_instr(6'd21, 1'b0, 1'b1);
        push_instr(6'd21, 1'b1, 1'b0);
        push_instr(6'd22, 1'b0, 1'b0);
        push_instr(6'd23, 1'b0, 1'b0);
        push_instr(6'd24, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            opcode = r.op; zero = r.z; sign = r.s; hold = r.h;
            #1;
            checks++;
            if (act !== r.o) begin
                errors++;
                $display("FAIL branch_jump: op=%0d z=%b s=%b got %h required %h", r.op, r.z, r.s, act, r.o);
            end
            if (r.o.done) exp_count++;
            @(negedge clk);
        end
        checks++;
        if (instr_count !== exp_count[15:0]) begin
            errors++;
            $display("FAIL branch_count: got %0d required %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_hold;
        rec_t hr;
        push_instr(6'd0, 1'b0, 1'b0);
        hr = sb[0]; hr.h = 1'b1; hr.o.pcw = 1'b0; hr.o.irw = 1'b0;
        sb.insert(0, hr);
        push_instr(6'd11, 1'b0, 1'b0);
        hr = sb[8]; hr.h = 1'b1; hr.o.mr = 1'b0;
        repeat (3) sb.insert(8, hr);
        push_instr(6'd19, 1'b1, 1'b0);
        hr = sb[15]; hr.h = 1'b1; hr.o.pcw = 1'b0; hr.o.done = 1'b0;
        repeat (2) sb.insert(15, hr);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            opcode = r.op; zero = r.z; sign = r.s; hold = r.h;
            #1;
            checks++;
            if (act !== r.o) begin
                errors++;
                $display("FAIL hold: op=%0d hold=%b got %h required %h", r.op, r.h, act, r.o);
            end
            if (r.o.done) exp_count++;
            @(negedge clk);
        end
        checks++;
        if (instr_count !== exp_count[15:0]) begin
            errors++;
            $display("FAIL hold_count: got %0d required %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_mul;
        push_instr(6'd15, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            opcode = r.op; zero = r.z; sign = r.s; hold = r.h;
            #1;
            checks++;
            if (act !== r.o) begin
                errors++;
                $display("FAIL mul: en=%b got %h required %h", MUL_EN, act, r.o);
            end
            if (r.o.done) exp_count++;
            @(negedge clk);
        end
        checks++;
        if (illegal !== !MUL_EN) begin
            errors++;
            $display("FAIL mul_illegal: got %b required %b", illegal, !MUL_EN);
        end
        if (!MUL_EN) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            exp_count = 0;
        end
    endtask

    task automatic test_halt;
        rec_t hr;
        push_instr(6'h3F, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            hr = base(6'($urandom_range(0, 63)), 1'b0, 1'b0, 3'd7);
            hr.h = 1'($urandom_range(0, 1));
            sb.push_back(hr);
        end
        while (sb.size() > 0) begin
            r = sb.pop_front();
            opcode = r.op; zero = r.z; sign = r.s; hold = r.h;
            #1;
            checks++;
            if (act !== r.o) begin
                errors++;
                $display("FAIL halt: op=%0d got %h required %h", r.op, act, r.o);
            end
            @(negedge clk);
        end
        hold = 1'b0;
        checks++;
        if (illegal !== 1'b1 || state !== 3'd7) begin
            errors++;
            $display("FAIL halt_sticky: state=%0d illegal=%b required 7/1", state, illegal);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || illegal !== 1'b0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL halt_reset: state=%0d illegal=%b count=%0d required 0/0/0", state, illegal, instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_reset_mid;
        push_instr(6'd13, 1'b0, 1'b0);
        repeat (3) begin
            r = sb.pop_front();
            opcode = r.op; zero = r.z; sign = r.s; hold = r.h;
            #1;
            checks++;
            if (act !== r.o) begin
                errors++;
                $display("FAIL reset_mid_pre: got %h required %h", act, r.o);
            end
            @(negedge clk);
        end
        sb.delete();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || instr_done !== 1'b0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: state=%0d done=%b count=%0d required 0/0/0", state, instr_done, instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        push_instr(6'd23, 1'b0, 1'b0);
        push_instr(6'd5, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            opcode = r.op; zero = r.z; sign = r.s; hold = r.h;
            #1;
            checks++;
            if (act !== r.o) begin
                errors++;
                $display("FAIL reset_mid_post: op=%0d got %h required %h", r.op, act, r.o);
            end
            if (r.o.done) exp_count++;
            @(negedge clk);
        end
        checks++;
        if (instr_count !== exp_count[15:0]) begin
            errors++;
            $display("FAIL reset_mid_count: got %0d required %0d", instr_count, exp_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_hold();
        test_mul();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
